// File: rtl/dm_master_pkg.sv
// dm_master_pkg: size codes and FSM state encoding for the data-memory master
package dm_master_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;
endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: little-endian lane extract/extend for loads and lane merge for sub-word stores
module dm_lane_unit
    import dm_master_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] rdata_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata_i[{off_i, 3'b000} +: 8];
        h = rdata_i[{off_i[1], 4'b0000} +: 16];
        load_o = size_i == SZ_BYTE ? {{24{~uns_i & b[7]}}, b} :
                 size_i == SZ_HALF ? {{16{~uns_i & h[15]}}, h} : rdata_i;
        merge_o = rdata_i;
        if (size_i == SZ_BYTE) merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
        else merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i;
    end
endmodule

// File: rtl/dm_master.sv
// dm_master: turns CPU byte/half/word loads and stores into word accesses on the data RAM
module dm_master
    import dm_master_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              DM_cs,
    output logic              DM_r,
    output logic              DM_w,
    output logic [ADDR_W-1:0] DM_addr,
    output logic [31:0]       DM_wdata,
    input  logic [31:0]       DM_rdata
);
    state_t              state_q;
    logic [1:0]          size_q, off_q;
    logic                uns_q, resp_valid_q, resp_err_q;
    logic [15:0]         wdata_q;
    logic [31:0]         resp_rdata_q, dm_wdata_q, load, merge;
    logic [ADDR_W-1:0]   dm_addr_q;
    logic                err, unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];
    assign err = req_size == 2'b11 || (req_size == SZ_HALF && req_addr[0]) ||
                 (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    dm_lane_unit u_lane (
        .size_i (size_q),
        .off_i  (off_q),
        .uns_i  (uns_q),
        .rdata_i(DM_rdata),
        .wdata_i(wdata_q),
        .load_o (load),
        .merge_o(merge)
    );

    // strobes are gated by rst so an abandoned RMW write never reaches the RAM
    assign DM_r = !rst && (state_q == LOAD || state_q == RMW_RD);
    assign DM_w = !rst && (state_q == STORE || state_q == RMW_WR);
    assign DM_cs = DM_r || DM_w;
    assign req_ready = state_q == IDLE;
    assign resp_valid = resp_valid_q;
    assign resp_err = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign DM_addr = dm_addr_q;
    assign DM_wdata = dm_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            size_q <= '0;
            off_q <= '0;
            uns_q <= 1'b0;
            wdata_q <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q <= 1'b0;
            resp_rdata_q <= '0;
            dm_addr_q <= '0;
            dm_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    size_q <= req_size;
                    off_q <= req_addr[1:0];
                    uns_q <= req_unsigned;
                    wdata_q <= req_wdata[15:0];
                    dm_addr_q <= req_addr[ADDR_W+1:2];
                    resp_err_q <= err;
                    resp_valid_q <= err;
                    resp_rdata_q <= '0;
                    if (!err && req_we && req_size == SZ_WORD) dm_wdata_q <= req_wdata;
                    state_q <= err ? RESP : !req_we ? LOAD : req_size == SZ_WORD ? STORE : RMW_RD;
                end
                LOAD: begin
                    resp_rdata_q <= load;
                    resp_valid_q <= 1'b1;
                    state_q <= RESP;
                end
                RMW_RD: begin
                    dm_wdata_q <= merge;
                    state_q <= RMW_WR;
                end
                STORE, RMW_WR: begin
                    resp_valid_q <= 1'b1;
                    state_q <= RESP;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_master.sv
// tb_dm_master: scoreboard bench for dm_master against a behavioural word RAM
module tb_dm_master;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        resp_valid, resp_err, DM_cs, DM_r, DM_w;
    logic [31:0] resp_rdata, DM_wdata, DM_rdata;
    logic [10:0] DM_addr;
    logic [31:0] mem [0:2047];
    int          checks = 0, errors = 0;

    typedef struct {logic [31:0] rd; logic err; int lat;} exp_t;
    exp_t sb_q[$];

    dm_master #(.ADDR_W(11)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .DM_cs(DM_cs), .DM_r(DM_r),
        .DM_w(DM_w), .DM_addr(DM_addr), .DM_wdata(DM_wdata), .DM_rdata(DM_rdata)
    );

    always #5 clk = ~clk;
    assign DM_rdata = mem[DM_addr];
    always @(posedge clk) if (DM_cs && DM_w) mem[DM_addr] <= DM_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                         input logic [10:0] exp_wa, input int exp_nr, input int exp_nw);
        int lat, nr, nw, ncs, badaddr;
        exp_t e;
        sb_q.push_back('{exp_rd, exp_err, exp_lat});
        chk("ready", {31'b0, req_ready}, 32'd1);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        lat = 1; nr = 0; nw = 0; ncs = 0; badaddr = 0;
        while (!resp_valid && lat < 10) begin
            ncs += int'(DM_cs); nr += int'(DM_r); nw += int'(DM_w);
            if (DM_cs && DM_addr != exp_wa) badaddr++;
            @(negedge clk);
            lat++;
        end
        chk("timeout", {31'b0, resp_valid}, 32'd1);
        e = sb_q.pop_front();
        chk("latency", lat, e.lat);
        chk("err", {31'b0, resp_err}, {31'b0, e.err});
        chk("rdata", resp_rdata, e.rd);
        chk("n_read", nr, exp_nr);
        chk("n_write", nw, exp_nw);
        chk("n_cs", ncs, exp_nr + exp_nw);
        chk("dm_addr", badaddr, 0);
        @(negedge clk);
        chk("resp_pulse", {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[5] = 32'h8899AABB;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_addr", {21'b0, DM_addr}, 32'd0);
        chk("rst_cs", {31'b0, DM_cs}, 32'd0);
        rst = 0;
        @(negedge clk);
        issue(0, 2'b00, 0, 32'h15, 0, 32'hFFFFFFAA, 0, 2, 11'd5, 1, 0);
        issue(0, 2'b01, 1, 32'h16, 0, 32'h00008899, 0, 2, 11'd5, 1, 0);
        issue(0, 2'b01, 0, 32'h14, 0, 32'hFFFFAABB, 0, 2, 11'd5, 1, 0);
        issue(0, 2'b00, 1, 32'h17, 0, 32'h00000088, 0, 2, 11'd5, 1, 0);
        issue(1, 2'b10, 0, 32'h20, 32'h12345678, 32'h0, 0, 2, 11'd8, 0, 1);
        chk("mem8_sw", mem[8], 32'h12345678);
        issue(0, 2'b10, 0, 32'h20, 0, 32'h12345678, 0, 2, 11'd8, 1, 0);
        issue(1, 2'b00, 0, 32'h15, 32'hFFFFFFEE, 32'h0, 0, 3, 11'd5, 1, 1);
        chk("mem5_sb", mem[5], 32'h8899EEBB);
        issue(1, 2'b01, 0, 32'h22, 32'h0000ABCD, 32'h0, 0, 3, 11'd8, 1, 1);
        chk("mem8_sh", mem[8], 32'hABCD5678);
        issue(0, 2'b01, 0, 32'h13, 0, 32'h0, 1, 1, 11'd0, 0, 0);
        issue(1, 2'b10, 0, 32'h22, 32'hDEADBEEF, 32'h0, 1, 1, 11'd0, 0, 0);
        issue(0, 2'b11, 0, 32'h40, 0, 32'h0, 1, 1, 11'd0, 0, 0);
        chk("mem8_err", mem[8], 32'hABCD5678);
        // sh interrupted by reset during its write cycle
        req_we = 1; req_size = 2'b01; req_unsigned = 0; req_addr = 32'h14; req_wdata = 32'h1234;
        req_valid = 1;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        chk("rmw_rd", {31'b0, DM_r}, 32'd1);
        @(negedge clk);
        rst = 1;
        #1 chk("rst_dm_w", {31'b0, DM_w}, 32'd0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("mid_mem5", mem[5], 32'h8899EEBB);
        chk("mid_valid", {31'b0, resp_valid}, 32'd0);
        chk("mid_err", {31'b0, resp_err}, 32'd0);
        chk("mid_rdata", resp_rdata, 32'd0);
        chk("mid_addr", {21'b0, DM_addr}, 32'd0);
        chk("mid_wdata", DM_wdata, 32'd0);
        chk("mid_cs", {31'b0, DM_cs}, 32'd0);
        issue(0, 2'b10, 0, 32'h14, 0, 32'h8899EEBB, 0, 2, 11'd5, 1, 0);
        issue(0, 2'b01, 0, 32'h22, 0, 32'hFFFFABCD, 0, 2, 11'd8, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_master.md
Name: dm_master

Overview:
- Initiator side of the data-memory bus: drives DM_cs/DM_r/DM_w, a word address and write data into the word-only data RAM, and takes its read data back.
- Sits between the CPU execute/memory stage and the data RAM.
- Converts MIPS byte/half/word loads and stores into word accesses: sign/zero extension on loads, read-modify-write for sub-word stores, misalignment detection.

Parameters:
ADDR_W, 11, word-address width on the memory side (byte address bits [ADDR_W+1:2])

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU request strobe, sampled only when req_ready=1
req_ready  out  1  high in IDLE only
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  zero-extend load (lbu/lhu); ignored for stores
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid: misaligned or reserved size, no memory access made
resp_rdata  out  32  extended load result, valid with resp_valid; 0 for stores/errors
DM_cs  out  1  memory chip select
DM_r  out  1  memory read enable
DM_w  out  1  memory write enable
DM_addr  out  ADDR_W  word address = latched req_addr[ADDR_W+1:2]
DM_wdata  out  32  word to write (to RAM data_in)
DM_rdata  in  32  RAM data_out; combinational, valid in the same cycle as DM_cs&DM_r

Behaviour:
- Reset: state=IDLE; resp_valid=0, resp_err=0, resp_rdata=0, DM_addr=0, DM_wdata=0, all latched request fields 0.
- DM_cs/DM_r/DM_w are Moore decodes of the state register, ANDed with !rst. No write commits in a cycle where rst=1.
- Request accept: in IDLE with req_valid=1 at edge T, latch we/size/unsigned/addr/wdata. Requests while busy are ignored; CPU must hold them.
- Error check at accept:
  - size=11 -> err.
  - half with addr[0]=1 -> err.
  - word with addr[1:0]!=0 -> err.
  - Error path: next state RESP, resp_err=1, no DM_cs ever asserted.
- States and transitions:
  - IDLE -> LOAD (load), STORE (sw), RMW_RD (sb/sh), RESP (error).
  - LOAD: DM_cs=DM_r=1. Capture DM_rdata at end of cycle, extract lane, extend into resp_rdata. -> RESP.
  - STORE: DM_cs=DM_w=1, DM_wdata=latched wdata. -> RESP.
  - RMW_RD: DM_cs=DM_r=1. Capture DM_rdata into merge register. -> RMW_WR.
  - RMW_WR: DM_cs=DM_w=1, DM_wdata=merged word. -> RESP.
  - RESP: resp_valid=1 for exactly one cycle. -> IDLE. req_ready=0 in RESP.
- Latency, counting cycles after the accept edge: lw/lb/lh=2, sw=2, sb/sh=3, error=1 (resp_valid high in cycle T+latency).
- Lanes are little-endian within a word:
  - byte k occupies [8k+7:8k], with k=addr[1:0];
  - half j occupies [16j+15:16j], with j=addr[1].
- Load extension: signed replicates lane MSB into [31:w]; unsigned fills 0. Word loads pass through.
- Merge: unselected lanes keep the RMW_RD captured value; the selected lane takes req_wdata low bits.
- DM_addr holds its last value when idle; it is not cleared between requests.
- Reset mid-operation: at the reset edge state->IDLE and resp_valid drops. A pending RMW write is abandoned; memory is untouched because DM_w is gated by rst.
- DM_rdata is ignored in every state except LOAD and RMW_RD.

Decomposition:
- Package dm_master_pkg: size codes (SZ_BYTE, SZ_HALF, SZ_WORD), state encoding (IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP).
- Sub-module dm_lane_unit (combinational): load extract/extend and store merge, selected by size, addr[1:0], unsigned.

Test Plan:
- Preload mem[5]=32'h8899AABB. Request lb at addr 0x15 -> resp_valid at T+2, resp_rdata=32'hFFFFFFAA, resp_err=0, one DM_r cycle at DM_addr=5.
- Same word, lhu at addr 0x16 -> resp_rdata=32'h00008899; lh at addr 0x14 -> 32'hFFFFAABB.
- sw 32'h12345678 at addr 0x20, then lw 0x20 -> DM_w one cycle at DM_addr=8, read returns 32'h12345678, latency 2 each.
- sb 8'hEE at addr 0x15 with mem[5]=32'h8899AABB -> RMW_RD then RMW_WR, mem[5]=32'h8899EEBB, resp at T+3.
- lh at addr 0x13, sw at addr 0x22, size=11 -> resp_valid at T+1 with resp_err=1, DM_cs never asserted.
- sh issued, rst asserted during RMW_WR -> DM_w=0 that cycle, mem unchanged, next cycle state IDLE, all outputs at reset values, new request accepted normally.
